// File: rtl/escalonador_contexto.sv
// escalonador_contexto
//   Round-robin context-switch scheduler. Keeps a table of NUM_PROC process
//   slots (valid bit + saved PC), services switch requests from the quantum
//   counter, process termination and process creation, and drives the PC
//   load interface with a single-cycle carrega_pc pulse.
//
// Ports
//   clock                in  system clock, rising edge
//   reset                in  asynchronous, active-low
//   troca_contexto       in  switch request (quantum expired / I/O)
//   pc_processo_trocado  in  [31:0] resume PC of outgoing process
//   fim_processo         in  running process terminates
//   cria_processo        in  create a process
//   pc_inicial           in  [31:0] start PC of created process
//   ocupado              out high while searching; requests ignored
//   carrega_pc           out 1-cycle pulse: PC must load pc_novo
//   pc_novo              out [31:0] PC of selected process
//   pid_atual            out [PID_W-1:0] slot of running process
//   sem_processo         out sticky: no valid process remains
//   erro_cheio           out 1-cycle pulse: creation refused, table full
module escalonador_contexto #(
  parameter int          NUM_PROC = 4,
  parameter int          PID_W    = 2,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             troca_contexto,
  input  logic [31:0]      pc_processo_trocado,
  input  logic             fim_processo,
  input  logic             cria_processo,
  input  logic [31:0]      pc_inicial,
  output logic             ocupado,
  output logic             carrega_pc,
  output logic [31:0]      pc_novo,
  output logic [PID_W-1:0] pid_atual,
  output logic             sem_processo,
  output logic             erro_cheio
);

  localparam logic [0:0] OCIOSO = 1'b0;
  localparam logic [0:0] BUSCA  = 1'b1;

  localparam logic [PID_W-1:0]    ULTIMO    = PID_W'(NUM_PROC - 1);
  localparam logic [PID_W-1:0]    UM        = PID_W'(1);
  localparam logic [NUM_PROC-1:0] VALID_RST = NUM_PROC'(1);

  logic [0:0]          state;
  logic [NUM_PROC-1:0] valid;
  logic [31:0]         pc_tab [NUM_PROC];
  logic [PID_W-1:0]    idx;
  logic [PID_W-1:0]    cnt;

  logic                livre_ok;
  logic [PID_W-1:0]    livre;

  // ocupado is taken straight from the state flop, so it is still registered
  assign ocupado = (state == BUSCA);

  // Lowest-index free slot for process creation
  always_comb begin
    livre_ok = 1'b0;
    livre    = '0;
    for (int unsigned i = 0; i < NUM_PROC; i++) begin
      if (!livre_ok && !valid[i]) begin
        livre_ok = 1'b1;
        livre    = PID_W'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= OCIOSO;
      valid        <= VALID_RST;
      for (int unsigned i = 0; i < NUM_PROC; i++) begin
        pc_tab[i] <= (i == 0) ? RESET_PC : '0;
      end
      idx          <= '0;
      cnt          <= '0;
      pid_atual    <= '0;
      pc_novo      <= RESET_PC;
      carrega_pc   <= 1'b0;
      sem_processo <= 1'b0;
      erro_cheio   <= 1'b0;
    end else begin
      carrega_pc <= 1'b0;
      erro_cheio <= 1'b0;
      case (state)
        OCIOSO: begin
          // Switch/terminate are ignored with no process, so creation is
          // still served in that condition even if they are raised with it.
          if (fim_processo && !sem_processo) begin
            valid[pid_atual] <= 1'b0;
            idx              <= pid_atual + UM;
            cnt              <= '0;
            state            <= BUSCA;
          end else if (troca_contexto && !sem_processo) begin
            pc_tab[pid_atual] <= pc_processo_trocado;
            idx               <= pid_atual + UM;
            cnt               <= '0;
            state             <= BUSCA;
          end else if (cria_processo) begin
            if (livre_ok) begin
              valid[livre]  <= 1'b1;
              pc_tab[livre] <= pc_inicial;
              if (sem_processo) begin
                pid_atual    <= livre;
                pc_novo      <= pc_inicial;
                carrega_pc   <= 1'b1;
                sem_processo <= 1'b0;
              end
            end else begin
              erro_cheio <= 1'b1;
            end
          end
        end
        BUSCA: begin
          // idx starts one past the running slot, so the running slot is
          // visited last (cnt == NUM_PROC-1)
          if (valid[idx]) begin
            pid_atual  <= idx;
            pc_novo    <= pc_tab[idx];
            carrega_pc <= 1'b1;
            state      <= OCIOSO;
          end else if (cnt == ULTIMO) begin
            sem_processo <= 1'b1;
            state        <= OCIOSO;
          end else begin
            idx <= idx + UM;
            cnt <= cnt + UM;
          end
        end
        default: state <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_contexto.sv
// tb_escalonador_contexto
//   Directed and random stimulus for escalonador_contexto against a slot-table
//   reference model (valid flags, saved PCs, running pid).
module tb_escalonador_contexto;

  localparam int          N   = 4;
  localparam int          PW  = 2;
  localparam logic [31:0] RPC = 32'h0000_0040;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          troca_contexto = 1'b0;
  logic [31:0]   pc_processo_trocado = '0;
  logic          fim_processo = 1'b0;
  logic          cria_processo = 1'b0;
  logic [31:0]   pc_inicial = '0;
  logic          ocupado;
  logic          carrega_pc;
  logic [31:0]   pc_novo;
  logic [PW-1:0] pid_atual;
  logic          sem_processo;
  logic          erro_cheio;

  int errors = 0;
  int checks = 0;

  bit          mv  [N];
  logic [31:0] mpc [N];
  int          mpid;
  logic [31:0] mpcnovo;
  bit          msem;

  escalonador_contexto #(.NUM_PROC(N), .PID_W(PW), .RESET_PC(RPC)) dut (
    .clock              (clock),
    .reset              (reset),
    .troca_contexto     (troca_contexto),
    .pc_processo_trocado(pc_processo_trocado),
    .fim_processo       (fim_processo),
    .cria_processo      (cria_processo),
    .pc_inicial         (pc_inicial),
    .ocupado            (ocupado),
    .carrega_pc         (carrega_pc),
    .pc_novo            (pc_novo),
    .pid_atual          (pid_atual),
    .sem_processo       (sem_processo),
    .erro_cheio         (erro_cheio)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i]  = (i == 0);
      mpc[i] = (i == 0) ? RPC : 32'h0;
    end
    mpid    = 0;
    mpcnovo = RPC;
    msem    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ":ocupado"},    32'(ocupado),      32'd0);
    chk({tag, ":carrega"},    32'(carrega_pc),   32'd0);
    chk({tag, ":pid"},        32'(pid_atual),    32'd0);
    chk({tag, ":pc_novo"},    pc_novo,           RPC);
    chk({tag, ":sem"},        32'(sem_processo), 32'd0);
    chk({tag, ":erro_cheio"}, 32'(erro_cheio),   32'd0);
  endtask

  // Assert reset, check immediately (asynchronous), release on a falling edge
  task automatic apply_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_outputs(tag);
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Round-robin distance from the running slot to the next valid slot
  function automatic int dist_next();
    for (int d = 1; d <= N; d++) begin
      if (mv[(mpid + d) % N]) return d;
    end
    return 0;
  endfunction

  function automatic int free_slot();
    for (int i = 0; i < N; i++) begin
      if (!mv[i]) return i;
    end
    return -1;
  endfunction

  // One request cycle, then follow the DUT until it is idle again.
  // Called and returns on a falling clock edge.
  task automatic op(input bit f, input bit t, input logic [31:0] pc,
                    input bit c, input logic [31:0] pci, input string tag);
    int d;
    int lat;
    int s;
    fim_processo        = f;
    troca_contexto      = t;
    pc_processo_trocado = pc;
    cria_processo       = c;
    pc_inicial          = pci;
    @(negedge clock);
    fim_processo   = 1'b0;
    troca_contexto = 1'b0;
    cria_processo  = 1'b0;
    if (!msem && (f || t)) begin
      if (f) mv[mpid] = 1'b0;
      else   mpc[mpid] = pc;
      d = dist_next();
      chk({tag, ":ocupado_busca"}, 32'(ocupado), 32'd1);
      lat = 0;
      for (int cyc = 1; cyc <= N + 2; cyc++) begin
        @(negedge clock);
        if (carrega_pc) begin
          lat = cyc;
          break;
        end
        if (!ocupado) break;
      end
      chk({tag, ":latencia"}, 32'(lat), 32'(d));
      if (d > 0) begin
        mpid    = (mpid + d) % N;
        mpcnovo = mpc[mpid];
        chk({tag, ":pc_novo"}, pc_novo, mpcnovo);
        chk({tag, ":pid"},     32'(pid_atual), 32'(mpid));
        @(negedge clock);
        chk({tag, ":carrega_pulso"}, 32'(carrega_pc), 32'd0);
        chk({tag, ":ocupado_fim"},   32'(ocupado),    32'd0);
      end else begin
        msem = 1'b1;
        chk({tag, ":sem"},         32'(sem_processo), 32'd1);
        chk({tag, ":ocupado_fim"}, 32'(ocupado),      32'd0);
        chk({tag, ":pc_novo"},     pc_novo,           mpcnovo);
      end
    end else if (c) begin
      s = free_slot();
      if (s < 0) begin
        chk({tag, ":erro_cheio"}, 32'(erro_cheio), 32'd1);
        chk({tag, ":carrega"},    32'(carrega_pc), 32'd0);
      end else begin
        mv[s]  = 1'b1;
        mpc[s] = pci;
        chk({tag, ":erro_cheio"}, 32'(erro_cheio), 32'd0);
        if (msem) begin
          msem    = 1'b0;
          mpid    = s;
          mpcnovo = pci;
          chk({tag, ":carrega"}, 32'(carrega_pc), 32'd1);
        end else begin
          chk({tag, ":carrega"}, 32'(carrega_pc), 32'd0);
        end
      end
      chk({tag, ":sem"},     32'(sem_processo), 32'(msem));
      chk({tag, ":pid"},     32'(pid_atual),    32'(mpid));
      chk({tag, ":pc_novo"}, pc_novo,           mpcnovo);
      chk({tag, ":ocupado"}, 32'(ocupado),      32'd0);
      @(negedge clock);
      chk({tag, ":erro_pulso"},    32'(erro_cheio), 32'd0);
      chk({tag, ":carrega_pulso"}, 32'(carrega_pc), 32'd0);
    end else begin
      chk({tag, ":ignorado_ocupado"}, 32'(ocupado),      32'd0);
      chk({tag, ":ignorado_carrega"}, 32'(carrega_pc),   32'd0);
      chk({tag, ":ignorado_sem"},     32'(sem_processo), 32'(msem));
    end
  endtask

  initial begin
    bit          saw;
    int          kind;
    logic [31:0] rpc;

    #2;
    apply_reset("reset");

    // Lone process 0: full-table search, same slot reselected with saved PC
    op(0, 1, 32'd55, 0, 32'd0, "lone");
    chk("lone:pc55", pc_novo, 32'd55);

    // Creation without switching
    op(0, 0, 32'd0, 1, 32'd100, "cria100");
    op(0, 0, 32'd0, 1, 32'd200, "cria200");
    chk("cria:pid0", 32'(pid_atual), 32'd0);

    // Round-robin 0 -> 1 -> 2 -> 0
    op(0, 1, 32'd17, 0, 32'd0, "troca17");
    chk("troca17:pc100", pc_novo, 32'd100);
    chk("troca17:pid1",  32'(pid_atual), 32'd1);
    op(0, 1, 32'd111, 0, 32'd0, "troca111");
    chk("troca111:pc200", pc_novo, 32'd200);
    op(0, 1, 32'd222, 0, 32'd0, "troca222");
    chk("troca222:pc17", pc_novo, 32'd17);

    // Fill the table, then one refused creation
    op(0, 0, 32'd0, 1, 32'd300, "cria300");
    op(0, 0, 32'd0, 1, 32'd400, "cheio");

    // Termination beats switch in the same cycle: slot 0 gone, PC not saved
    op(1, 1, 32'd999, 0, 32'd0, "fim_troca");
    chk("fim_troca:pc111", pc_novo, 32'd111);

    // Terminate everything remaining
    op(1, 0, 32'd0, 0, 32'd0, "fim1");
    op(1, 0, 32'd0, 0, 32'd0, "fim2");
    op(1, 0, 32'd0, 0, 32'd0, "fim3");
    chk("vazio:sem", 32'(sem_processo), 32'd1);
    op(0, 1, 32'd5, 0, 32'd0, "vazio_troca");
    op(1, 0, 32'd0, 0, 32'd0, "vazio_fim");
    op(0, 0, 32'd0, 1, 32'd300, "vazio_cria");
    chk("vazio_cria:pc300", pc_novo, 32'd300);
    chk("vazio_cria:sem0", 32'(sem_processo), 32'd0);

    // Reset in the middle of a search: no load afterwards
    apply_reset("reset2");
    troca_contexto      = 1'b1;
    pc_processo_trocado = 32'd77;
    @(negedge clock);
    troca_contexto = 1'b0;
    @(negedge clock);
    chk("mid_busca:ocupado", 32'(ocupado), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("mid_reset");
    @(negedge clock);
    reset = 1'b1;
    saw = 1'b0;
    repeat (N + 2) begin
      @(negedge clock);
      if (carrega_pc || ocupado) saw = 1'b1;
    end
    chk("mid_reset:sem_carga", 32'(saw), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      rpc  = $urandom;
      if (kind <= 2)      op(0, 0, 32'd0, 1, rpc, "rnd_cria");
      else if (kind <= 6) op(0, 1, rpc, 0, 32'd0, "rnd_troca");
      else if (kind <= 8) op(1, 0, 32'd0, 0, 32'd0, "rnd_fim");
      else                op(1, 1, rpc, 0, 32'd0, "rnd_fim_troca");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
